wave_period_meter: RTL and testbench
====================================

Name: wave_period_meter

Overview:
- Measures the period of a generated waveform, the inverse of the DDS path (waveform in, period count out).
- Consumes the M-bit unsigned sample stream at the sample-rate strobe.
- Detects rising midscale crossings with hysteresis and averages the period over 2^AVG_LOG2 cycles.
- Used as an on-chip self-check of the tuning word → output frequency, and as a measurement front end.

Parameters:
- M, 12, sample width (unsigned, midscale = 2^(M-1))
- CNT_W, 20, width of the tick accumulator and the period output
- AVG_LOG2, 2, log2 of the number of periods averaged (1..4)
- HYST, 64, hysteresis half-band in LSBs around midscale

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sample_en  in  1  one-cycle strobe, sample valid this cycle
- sample  in  M  waveform sample, unsigned
- start  in  1  one-cycle request to begin a measurement
- busy  out  1  measurement in progress
- period  out  CNT_W  averaged period in sample_en ticks, held until next result
- period_valid  out  1  one-cycle pulse when period updates
- timeout  out  1  one-cycle pulse on measurement abort

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, period=0, period_valid=0, timeout=0, comparator level lo, all counters 0. Applies mid-measurement; no result or timeout is emitted.
- Thresholds: TH_HI = min(mid+HYST, 2^M-1), TH_LO = max(mid-HYST, 0), computed at elaboration.
- Comparator updates only on sample_en, in every state:
  - lo→hi when sample >= TH_HI.
  - hi→lo when sample < TH_LO.
  - Otherwise holds.
  - edge = sample_en & lo→hi transition this cycle (combinational from registered level and current sample).
- FSM:
  - IDLE: busy=0. start → SYNC next cycle.
  - SYNC: busy=1.
    - On edge: acc←0, edges←0, go MEASURE.
    - Each sample_en without edge: acc←acc+1.
    - If acc reaches 2^CNT_W-1: timeout pulse, go IDLE.
  - MEASURE: busy=1.
    - Each sample_en: acc←acc+1.
    - On edge: edges←edges+1.
    - When the edge makes edges = 2^AVG_LOG2: period←(acc+1)>>AVG_LOG2 (truncate), period_valid=1 next cycle, go IDLE.
    - If acc+1 would exceed 2^CNT_W-1 before that: timeout pulse, period unchanged, go IDLE.
- Cycles without sample_en change nothing except FSM start handling. The result is in sample ticks, independent of strobe spacing.
- Latency: period_valid and busy=0 appear on the cycle after the final-edge sample_en.
- A square wave of P ticks yields period=P exactly. Non-integer periods yield the truncated mean.
- start while busy: ignored. start on the same cycle period_valid pulses: accepted (FSM already IDLE).
- Edge on the same sample_en that enters SYNC (start cycle): not seen; SYNC begins the cycle after start.
- period_valid and timeout are mutually exclusive and never asserted outside their single cycle.

Optional Feature:
- Macro PERIOD_JITTER_EN.
- Defined:
  - Adds output port jitter (CNT_W) and tracks per-period tick counts within MEASURE using a separate single-period counter, reset at each edge.
  - Running min/max are initialised at the first complete period.
  - jitter = max-min, updated together with period, reset 0.
  - With AVG_LOG2 periods all equal, jitter=0.
- Undefined: no port, no min/max registers, behaviour otherwise identical.

Decomposition:
- Shared package dds_pkg:
  - FSM state typedef {IDLE, SYNC, MEASURE}.
  - Midscale/threshold helper functions.
  - Default M (12), matching the waveform generator output width.
- One sub-module: hyst_comparator (sample, sample_en, TH_HI/TH_LO params → level, edge).
- FSM, counters and result registers live in the top.

Test Plan:
- Square wave 0/4095, period 10 ticks, sample_en every cycle, AVG_LOG2=2, start → busy=1, period_valid after 4 edges post-sync, period=10, busy=0 same cycle.
- Same wave with sample_en every 3rd cycle → period=10. Alternating periods 9/10 → period=9 (38>>2); with PERIOD_JITTER_EN, jitter=1.
- Sample toggling 2048±50 (inside HYST=64) for 1000 ticks, CNT_W=8 → no edges, timeout pulse after 255 sample ticks in SYNC, period unchanged.
- Assert rst during MEASURE after 2 edges → outputs to reset values immediately; no valid/timeout. Subsequent start measures correctly.
- start pulses while busy (in SYNC and MEASURE) → ignored, single result. start coincident with period_valid → new SYNC begins next cycle.
- Sine of period 64 ticks from the DDS sine path → period=64 ±0; with noise inside HYST, no extra edges counted.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg: shared sample width, FSM state encoding and midscale/threshold helpers
// for the DDS generator and the wave period meter.
package dds_pkg;

    localparam int DDS_M = 12;

    typedef logic [1:0] state_t;
    localparam state_t IDLE    = 2'd0;
    localparam state_t SYNC    = 2'd1;
    localparam state_t MEASURE = 2'd2;

    function automatic int mid_of(input int m);
        return 1 << (m - 1);
    endfunction

    // Thresholds saturate to the sample range when HYST is wider than half-scale.
    function automatic int th_hi_of(input int m, input int hyst);
        return (mid_of(m) + hyst > (1 << m) - 1) ? (1 << m) - 1 : mid_of(m) + hyst;
    endfunction

    function automatic int th_lo_of(input int m, input int hyst);
        return (mid_of(m) - hyst < 0) ? 0 : mid_of(m) - hyst;
    endfunction

endpackage

// File: rtl/hyst_comparator.sv
// hyst_comparator: midscale crossing detector with hysteresis; rise flags the
// strobed sample that moves the registered level from lo to hi.
module hyst_comparator
    import dds_pkg::*;
#(
    parameter int M     = DDS_M,
    parameter int TH_HI = th_hi_of(DDS_M, 64),
    parameter int TH_LO = th_lo_of(DDS_M, 64)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_en,
    input  logic [M-1:0] sample,
    output logic         rise
);

    localparam logic [M-1:0] HI = TH_HI[M-1:0];
    localparam logic [M-1:0] LO = TH_LO[M-1:0];

    logic level_q, level_d;

    always_comb begin
        level_d = !sample_en ? level_q : level_q ? (sample >= LO) : (sample >= HI);
    end

    assign rise = sample_en && !level_q && (sample >= HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level_d;
    end

endmodule

// File: rtl/wave_period_meter.sv
// wave_period_meter: averages the rising-crossing period of a sample stream over
// 2^AVG_LOG2 cycles, in sample_en ticks. Define PERIOD_JITTER_EN to add the jitter port.
module wave_period_meter
    import dds_pkg::*;
#(
    parameter int M        = DDS_M,
    parameter int CNT_W    = 20,
    parameter int AVG_LOG2 = 2,
    parameter int HYST     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [M-1:0]     sample,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             timeout
`ifdef PERIOD_JITTER_EN
    ,
    output logic [CNT_W-1:0] jitter
`endif
);

    localparam int                 NE_INT  = 1 << AVG_LOG2;
    localparam logic [AVG_LOG2:0]  NE      = NE_INT[AVG_LOG2:0];
    localparam logic [CNT_W-1:0]   ACC_MAX = '1;
    localparam logic [CNT_W:0]     ACC_TOP = {1'b0, ACC_MAX};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [AVG_LOG2:0] edges_q, edges_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W:0]    acc_inc;
    logic [AVG_LOG2:0] edges_inc;
    logic              rise;

    hyst_comparator #(
        .M     (M),
        .TH_HI (th_hi_of(M, HYST)),
        .TH_LO (th_lo_of(M, HYST))
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .sample    (sample),
        .rise      (rise)
    );

    assign acc_inc   = {1'b0, acc_q} + (CNT_W + 1)'(1);
    assign edges_inc = edges_q + (AVG_LOG2 + 1)'(1);

`ifdef PERIOD_JITTER_EN
    logic [CNT_W-1:0] per_q, per_d, min_q, min_d, max_q, max_d, jit_q, jit_d;
    logic [CNT_W-1:0] per_inc, nmin, nmax;
    // The first complete period seeds both extremes.
    assign per_inc = per_q + CNT_W'(1);
    assign nmin    = (edges_q == '0 || per_inc < min_q) ? per_inc : min_q;
    assign nmax    = (edges_q == '0 || per_inc > max_q) ? per_inc : max_q;
    assign jitter  = jit_q;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        edges_d   = edges_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
`ifdef PERIOD_JITTER_EN
        per_d     = per_q;
        min_d     = min_q;
        max_d     = max_q;
        jit_d     = jit_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = SYNC;
                acc_d   = '0;
            end
            SYNC: if (sample_en) begin
                if (rise) begin
                    state_d = MEASURE;
                    acc_d   = '0;
                    edges_d = '0;
`ifdef PERIOD_JITTER_EN
                    per_d   = '0;
`endif
                end else begin
                    acc_d = CNT_W'(acc_inc);
                    if (acc_inc == ACC_TOP) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            MEASURE: if (sample_en) begin
                if (acc_q == ACC_MAX) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    acc_d = CNT_W'(acc_inc);
                    if (rise) edges_d = edges_inc;
`ifdef PERIOD_JITTER_EN
                    per_d = rise ? '0 : per_inc;
                    if (rise) begin
                        min_d = nmin;
                        max_d = nmax;
                    end
`endif
                    if (rise && edges_inc == NE) begin
                        period_d = CNT_W'(acc_inc >> AVG_LOG2);
                        valid_d  = 1'b1;
                        state_d  = IDLE;
`ifdef PERIOD_JITTER_EN
                        jit_d    = nmax - nmin;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            edges_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef PERIOD_JITTER_EN
            per_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            jit_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            edges_q   <= edges_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
`ifdef PERIOD_JITTER_EN
            per_q     <= per_d;
            min_q     <= min_d;
            max_q     <= max_d;
            jit_q     <= jit_d;
`endif
        end
    end

    assign busy         = state_q != IDLE;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_wave_period_meter.sv
// tb_wave_period_meter: directed self-checking bench with a result scoreboard.
module tb_wave_period_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic [11:0] sample = 12'd0;
    logic        start = 1'b0;
    logic        start8 = 1'b0;
    logic        busy, period_valid, timeout;
    logic [19:0] period;
    logic        busy8, period_valid8, timeout8;
    logic [7:0]  period8;
`ifdef PERIOD_JITTER_EN
    logic [19:0] jitter;
    logic [7:0]  jitter8;
`endif

    typedef struct {int period; int jitter;} exp_t;
    exp_t exp_q[$];

    int nvec = 0, nerr = 0;
    int nvalid = 0, extra = 0, nto = 0, nto8 = 0, nvalid8 = 0;

    always #5 clk = ~clk;

    wave_period_meter #(.M(12), .CNT_W(20), .AVG_LOG2(2), .HYST(64)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .sample(sample), .start(start),
        .busy(busy), .period(period), .period_valid(period_valid), .timeout(timeout)
`ifdef PERIOD_JITTER_EN
        , .jitter(jitter)
`endif
    );

    wave_period_meter #(.M(12), .CNT_W(8), .AVG_LOG2(2), .HYST(64)) dut8 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .sample(sample), .start(start8),
        .busy(busy8), .period(period8), .period_valid(period_valid8), .timeout(timeout8)
`ifdef PERIOD_JITTER_EN
        , .jitter(jitter8)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (period_valid) begin
            nvalid++;
            if (exp_q.size() == 0) extra++;
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("period", 32'(period), e.period);
                chk("busy_at_valid", 32'(busy), 0);
`ifdef PERIOD_JITTER_EN
                chk("jitter", 32'(jitter), e.jitter);
`endif
            end
        end
        if (timeout) nto++;
        if (timeout8) nto8++;
        if (period_valid8) nvalid8++;
    end

    task automatic tick(input logic [11:0] s, input int gap, input bit st);
        sample_en = 1'b1;
        sample    = s;
        start     = st;
        @(negedge clk);
        sample_en = 1'b0;
        start     = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
    endtask

    // mode 1: extra start pulses while busy; mode 2: restart on the valid pulse
    task automatic wave(input int pa, input int pb, input int ncyc, input int gap, input int mode);
        int k, p;
        bit st, st_next, armed;
        k = 0;
        st_next = 1'b0;
        armed = (mode == 2);
        for (int c = 0; c < ncyc; c++) begin
            p = (c % 2 == 1) ? pb : pa;
            for (int ph = 0; ph < p; ph++) begin
                st = st_next || (mode == 1 && (k == 2 || k == 20));
                tick((ph < p / 2) ? 12'd0 : 12'hfff, gap, st);
                if (st_next) begin
                    chk("busy_after_restart", 32'(busy), 1);
                    st_next = 1'b0;
                end
                k++;
                if (armed && period_valid) begin
                    st_next = 1'b1;
                    armed = 1'b0;
                end
            end
        end
    endtask

    task automatic sine(input int per, input int nticks);
        real v;
        int s;
        for (int n = 0; n < nticks; n++) begin
            v = 2048.0 + 2047.0 * $sin(2.0 * 3.14159265358979 * n / per);
            s = int'(v) + int'($urandom_range(40)) - 20;
            s = (s < 0) ? 0 : (s > 4095) ? 4095 : s;
            tick(s[11:0], 0, 1'b0);
        end
    endtask

    task automatic drain(input string tag, input int want_valid);
        repeat (4) @(negedge clk);
        chk(tag, 32'(nvalid), want_valid);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int to_k;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_valid", 32'(period_valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
`ifdef PERIOD_JITTER_EN
        chk("rst_jitter", 32'(jitter), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        exp_q.push_back('{10, 0});
        do_start();
        wave(10, 10, 7, 0, 0);
        drain("sq10_count", 1);

        exp_q.push_back('{10, 0});
        do_start();
        wave(10, 10, 7, 2, 0);
        drain("sq10_gap_count", 2);

        exp_q.push_back('{9, 1});
        do_start();
        wave(9, 10, 8, 0, 0);
        drain("alt_count", 3);

        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("busy8_after_start", 32'(busy8), 1);
        to_k = 0;
        for (int k = 1; k <= 300; k++) begin
            tick((k % 2 == 1) ? 12'd2098 : 12'd1998, 0, 1'b0);
            if (timeout8 && to_k == 0) to_k = k;
        end
        chk("timeout_tick", 32'(to_k), 255);
        chk("timeout_count", 32'(nto8), 1);
        chk("timeout_period", 32'(period8), 0);
        chk("timeout_busy", 32'(busy8), 0);
        chk("timeout_no_valid", 32'(nvalid8), 0);

        do_start();
        wave(10, 10, 3, 0, 0);
        chk("busy_before_rst", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_period", 32'(period), 0);
        chk("mid_rst_valid", 32'(period_valid), 0);
        chk("mid_rst_timeout", 32'(timeout), 0);
`ifdef PERIOD_JITTER_EN
        chk("mid_rst_jitter", 32'(jitter), 0);
`endif
        #1 rst = 1'b0;
        @(negedge clk);
        exp_q.push_back('{10, 0});
        do_start();
        wave(10, 10, 7, 0, 0);
        drain("after_rst_count", 4);

        exp_q.push_back('{10, 0});
        do_start();
        wave(10, 10, 8, 0, 1);
        drain("start_busy_count", 5);

        exp_q.push_back('{10, 0});
        exp_q.push_back('{10, 0});
        do_start();
        wave(10, 10, 14, 0, 2);
        drain("restart_count", 7);

        exp_q.push_back('{64, 0});
        do_start();
        sine(64, 64 * 7);
        drain("sine_count", 8);

        chk("extra_valids", 32'(extra), 0);
        chk("main_timeouts", 32'(nto), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
